// File: rtl/mioc_wait_ctrl_if.sv
// rtl/mioc_wait_ctrl_if.sv - CPU request and RAM/IO device bus bundle for mioc_wait_ctrl
// master = the controller; slave = the CPU/device side driving requests, read data and acks.
interface mioc_wait_ctrl_if #(
  parameter int NUM_IO = 4
);
  logic                   memCe;
  logic                   memWr;
  logic [31:0]            memAddr;
  logic [31:0]            wtData;
  logic [31:0]            rdData;
  logic                   memStall;
  logic                   busErr;
  logic                   ramCe;
  logic                   ramWe;
  logic [31:0]            ramAddr;
  logic [31:0]            ramWtData;
  logic [31:0]            ramRdData;
  logic [NUM_IO-1:0]      ioCe;
  logic                   ioWe;
  logic [31:0]            ioAddr;
  logic [31:0]            ioWtData;
  logic [32*NUM_IO-1:0]   ioRdData;
  logic [NUM_IO-1:0]      ioAck;

  modport master (
    input  memCe, memWr, memAddr, wtData, ramRdData, ioRdData, ioAck,
    output rdData, memStall, busErr, ramCe, ramWe, ramAddr, ramWtData,
           ioCe, ioWe, ioAddr, ioWtData
  );

  modport slave (
    output memCe, memWr, memAddr, wtData, ramRdData, ioRdData, ioAck,
    input  rdData, memStall, busErr, ramCe, ramWe, ramAddr, ramWtData,
           ioCe, ioWe, ioAddr, ioWtData
  );
endinterface

// File: rtl/mioc_wait_ctrl.sv
// rtl/mioc_wait_ctrl.sv - memory/IO decode controller with RAM wait states, IO ack handshake and bus errors
// Optional IO wait timeout is enabled by defining MIOC_TIMEOUT_EN.
module mioc_wait_ctrl #(
  parameter int         NUM_IO      = 4,
  parameter logic [3:0] IO_NIB      = 4'h7,
  parameter int         RAM_LAT     = 2,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  mioc_wait_ctrl_if.master bus
);

  localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RAM_WAIT, S_IO_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    ch_q, ch_d;
  logic          err_q, err_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic              req_io;
  logic              req_mapped;
  logic [NUM_IO-1:0] ch_onehot;
  logic              ack_sel;
  logic [31:0]       io_rd_sel;
  logic              expired;

`ifdef MIOC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt_q <= '0;
    else     tcnt_q <= tcnt_d;
  end

  assign expired = (tcnt_q == TW'(TIMEOUT_CYC - 1));
`else
  assign expired = 1'b0;
`endif

  assign req_io     = (bus.memAddr[31:28] == IO_NIB);
  assign req_mapped = ({1'b0, bus.memAddr[27:24]} < 5'(NUM_IO));

  // Channel one-hot, ack and read-data mux all follow the latched channel.
  always_comb begin
    ch_onehot = '0;
    ack_sel   = 1'b0;
    io_rd_sel = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      ch_onehot[k] = (ch_q == 4'(k));
      ack_sel      = ack_sel | (ch_onehot[k] & bus.ioAck[k]);
      io_rd_sel    = io_rd_sel | ({32{ch_onehot[k]}} & bus.ioRdData[32*k +: 32]);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ch_d      = ch_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
`ifdef MIOC_TIMEOUT_EN
    tcnt_d    = tcnt_q;
`endif
    bus.rdData    = rd_data_q;
    bus.memStall  = 1'b0;
    bus.busErr    = 1'b0;
    bus.ramCe     = 1'b0;
    bus.ramWe     = 1'b0;
    bus.ramAddr   = '0;
    bus.ramWtData = '0;
    bus.ioCe      = '0;
    bus.ioWe      = 1'b0;
    bus.ioAddr    = '0;
    bus.ioWtData  = '0;

    case (state_q)
      S_IDLE: begin
        bus.memStall = bus.memCe;
        if (bus.memCe) begin
          wr_d    = bus.memWr;
          addr_d  = bus.memAddr;
          wdata_d = bus.wtData;
          ch_d    = bus.memAddr[27:24];
          err_d   = 1'b0;
          if (!req_io) begin
            state_d = S_RAM_WAIT;
            cnt_d   = CW'(RAM_LAT - 1);
          end else if (req_mapped) begin
            state_d = S_IO_WAIT;
`ifdef MIOC_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end else begin
            state_d   = S_DONE;
            err_d     = 1'b1;
            rd_data_d = '0;
          end
        end
      end

      S_RAM_WAIT: begin
        bus.memStall  = 1'b1;
        bus.ramCe     = 1'b1;
        bus.ramWe     = wr_q;
        bus.ramAddr   = addr_q;
        bus.ramWtData = wdata_q;
        if (cnt_q == '0) begin
          rd_data_d = wr_q ? '0 : bus.ramRdData;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_IO_WAIT: begin
        bus.memStall = 1'b1;
        bus.ioCe     = ch_onehot;
        bus.ioWe     = wr_q;
        bus.ioAddr   = addr_q;
        bus.ioWtData = wdata_q;
        // An ack in the expiry cycle takes priority over the timeout.
        if (ack_sel) begin
          rd_data_d = wr_q ? '0 : io_rd_sel;
          state_d   = S_DONE;
        end else if (expired) begin
          rd_data_d = '0;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end
`ifdef MIOC_TIMEOUT_EN
        tcnt_d = tcnt_q + 1'b1;
`endif
      end

      S_DONE: begin
        bus.busErr = err_q;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // The stall path is combinational from memCe, so force it low under reset.
    if (rst) bus.memStall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ch_q      <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ch_q      <= ch_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_mioc_wait_ctrl.sv
// tb/tb_mioc_wait_ctrl.sv - self-checking bench for mioc_wait_ctrl
// A per-cycle timeline of expected phases is planned per access and compared every cycle.
module tb_mioc_wait_ctrl;

  localparam int NUM_IO  = 4;
  localparam int RAM_LAT = 2;
  localparam int TO      = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mioc_wait_ctrl_if #(.NUM_IO(NUM_IO)) bus ();

  mioc_wait_ctrl #(
    .NUM_IO(NUM_IO), .IO_NIB(4'h7), .RAM_LAT(RAM_LAT), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Timeline: 0 idle, 1 RAM wait, 2 IO wait, 3 done, 4 in reset.
  int          ph   [1024];
  logic        ewr  [1024];
  logic [31:0] eaddr[1024];
  logic [31:0] ewd  [1024];
  int          ech  [1024];
  logic        eerr [1024];
  logic [31:0] erd  [1024];

  int n_chk = 0;
  int n_err = 0;
  int n_stall, n_ramce, n_ioce;
  logic [3:0]  last_ioce;
  logic [31:0] done_rd;
  logic        done_err, done_stall;

  logic [31:0] exp_rd = '0;
  logic        e_ramce, e_ramwe, e_iowe, e_err, e_stall;
  logic [31:0] e_ramaddr, e_ramwd, e_ioaddr, e_iowd;
  logic [3:0]  e_ioce;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      e_ramce = 0; e_ramwe = 0; e_ramaddr = 0; e_ramwd = 0;
      e_ioce = 0; e_iowe = 0; e_ioaddr = 0; e_iowd = 0;
      e_err = 0; e_stall = 0;
      case (ph[cyc])
        0: e_stall = bus.memCe;
        1: begin
          e_stall = 1; e_ramce = 1; e_ramwe = ewr[cyc];
          e_ramaddr = eaddr[cyc]; e_ramwd = ewd[cyc];
        end
        2: begin
          e_stall = 1; e_ioce = 4'(1) << ech[cyc]; e_iowe = ewr[cyc];
          e_ioaddr = eaddr[cyc]; e_iowd = ewd[cyc];
        end
        3: begin e_err = eerr[cyc]; exp_rd = erd[cyc]; end
        default: exp_rd = '0;
      endcase
      chk("memStall", bus.memStall, e_stall);
      chk("busErr", bus.busErr, e_err);
      chk("rdData", bus.rdData, exp_rd);
      chk("ramCe", bus.ramCe, e_ramce);
      chk("ramWe", bus.ramWe, e_ramwe);
      chk("ramAddr", bus.ramAddr, e_ramaddr);
      chk("ramWtData", bus.ramWtData, e_ramwd);
      chk("ioCe", bus.ioCe, e_ioce);
      chk("ioWe", bus.ioWe, e_iowe);
      chk("ioAddr", bus.ioAddr, e_ioaddr);
      chk("ioWtData", bus.ioWtData, e_iowd);
      if (bus.memStall === 1'b1) n_stall++;
      if (bus.ramCe === 1'b1) n_ramce++;
      if (|bus.ioCe) begin n_ioce++; last_ioce = bus.ioCe; end
      if (ph[cyc] == 3) begin
        done_rd = bus.rdData; done_err = bus.busErr; done_stall = bus.memStall;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic plan(input int c0, input int kind, input int w, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd, input int ch,
                      input logic err, input logic [31:0] rd);
    for (int i = 1; i <= w; i++) begin
      ph[c0+i] = kind; ewr[c0+i] = wr; eaddr[c0+i] = a; ewd[c0+i] = wd; ech[c0+i] = ch;
    end
    ph[c0+w+1] = 3; eerr[c0+w+1] = err; erd[c0+w+1] = rd;
  endtask

  // Drives one access; memCe stays asserted through DONE and into the following cycle.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [3:0] wrong);
    int kind, w, ch, c0;
    logic err;
    logic [31:0] rd;
    logic [3:0] oh;
    ch = int'(a[27:24]); oh = '0; err = 0; rd = '0; kind = 0; w = 0;
    if (a[31:28] != 4'h7) begin
      kind = 1; w = RAM_LAT; rd = wr ? 32'h0 : bus.ramRdData;
    end else if (ch >= NUM_IO) begin
      err = 1;
    end else begin
      kind = 2; oh = 4'(1) << ch; w = ack_at;
      rd = wr ? 32'h0 : bus.ioRdData[32*ch +: 32];
`ifdef MIOC_TIMEOUT_EN
      if (ack_at == 0 || ack_at > TO) begin w = TO; err = 1; rd = '0; end
`endif
    end
    c0 = cyc;
    n_stall = 0; n_ramce = 0; n_ioce = 0; last_ioce = '0;
    bus.memCe = 1; bus.memWr = wr; bus.memAddr = a; bus.wtData = wd; bus.ioAck = '0;
    plan(c0, kind, w, wr, a, wd, ch, err, rd);
    for (int i = 1; i <= w + 1; i++) begin
      step();
      bus.ioAck = (kind == 2 && i <= w) ? ((wrong & ~oh) | ((i == ack_at) ? oh : 4'b0)) : 4'b0;
    end
    step();
  endtask

  task automatic idle(input int n);
    bus.memCe = 0; bus.memWr = 0; bus.memAddr = '0; bus.wtData = '0; bus.ioAck = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int c0;
    rst = 1;
    bus.memCe = 0; bus.memWr = 0; bus.memAddr = '0; bus.wtData = '0; bus.ioAck = '0;
    bus.ramRdData = 32'hDEAD_BEEF;
    bus.ioRdData  = {32'hC3C3_0003, 32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
    ph[0] = 4; ph[1] = 4; ph[2] = 4;
    step(); step(); step();
    rst = 0;
    idle(2);

    access(0, 32'h0000_0010, 32'h0, 0, 4'b0);
    chk("ram_rd_stall_cycles", n_stall, 3);
    chk("ram_rd_ramce_cycles", n_ramce, 2);
    chk("ram_rd_data", done_rd, 32'hDEAD_BEEF);
    chk("ram_rd_done_stall", done_stall, 0);
    chk("ram_rd_err", done_err, 0);
    idle(1);

    access(1, 32'h7200_0004, 32'h55, 3, 4'b0);
    chk("io_wr_ioce_cycles", n_ioce, 3);
    chk("io_wr_ioce", last_ioce, 4'b0100);
    chk("io_wr_err", done_err, 0);
    idle(1);

    access(0, 32'h7500_0000, 32'h0, 0, 4'b0);
    chk("unmapped_ioce_cycles", n_ioce, 0);
    chk("unmapped_err", done_err, 1);
    chk("unmapped_rd", done_rd, 32'h0);
    idle(1);

    access(1, 32'h0000_0100, 32'hA5A5_A5A5, 0, 4'b0);
    chk("ram_wr_rd", done_rd, 32'h0);
    idle(1);

    access(0, 32'h7000_0008, 32'h0, 4, 4'b0010);
    chk("wrong_ack_ioce_cycles", n_ioce, 4);
    chk("wrong_ack_rd", done_rd, 32'hC0C0_0000);
    idle(1);

    access(0, 32'h7300_0000, 32'h0, 1, 4'b0);
    chk("first_cycle_ack_ioce", n_ioce, 1);
    chk("first_cycle_ack_rd", done_rd, 32'hC3C3_0003);

    bus.ramRdData = 32'h1234_5678;
    access(0, 32'h8000_0020, 32'h0, 0, 4'b0);
    access(0, 32'h7100_0000, 32'h0, 2, 4'b0);
    chk("b2b_io_rd", done_rd, 32'hC1C1_0001);
    idle(1);

`ifdef MIOC_TIMEOUT_EN
    access(0, 32'h7100_0000, 32'h0, 0, 4'b0);
    chk("timeout_ioce_cycles", n_ioce, 8);
    chk("timeout_err", done_err, 1);
    chk("timeout_rd", done_rd, 32'h0);
    idle(1);
    access(0, 32'h7100_0000, 32'h0, 8, 4'b0);
    chk("ack_at_expiry_err", done_err, 0);
    chk("ack_at_expiry_rd", done_rd, 32'hC1C1_0001);
`else
    access(0, 32'h7100_0000, 32'h0, 20, 4'b0);
    chk("long_wait_ioce_cycles", n_ioce, 20);
    chk("long_wait_err", done_err, 0);
`endif
    idle(2);

    bus.ramRdData = 32'h0BAD_F00D;
    c0 = cyc;
    bus.memCe = 1; bus.memWr = 0; bus.memAddr = 32'h0000_0200; bus.wtData = '0;
    plan(c0, 1, RAM_LAT, 1'b0, 32'h0000_0200, 32'h0, 0, 1'b0, 32'h0BAD_F00D);
    ph[c0+2] = 4; ph[c0+3] = 0;
    step(); step();
    rst = 1;
    step();
    rst = 0;
    idle(3);
    chk("reset_rd_cleared", bus.rdData, 32'h0);

    access(0, 32'h0000_0300, 32'h0, 0, 4'b0);
    chk("after_reset_rd", done_rd, 32'h0BAD_F00D);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
